// File: rtl/fifo_pkg.sv
// Shared constants and types for the async FIFO and its write-side front end.
package fifo_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int FIFO_SIZE  = 16;
  localparam int CNT_WIDTH  = 16;
  localparam int PAD_VALUE  = 0;

  // Packer lane-counter state as seen by checkers: EMPTY means no partial word.
  typedef enum logic {
    PK_EMPTY   = 1'b0,
    PK_PARTIAL = 1'b1
  } pack_state_e;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = fifo_pkg::CNT_WIDTH
) (
  input  logic             wr_clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge wr_clk) begin
    if (rst)                    count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
  end
endmodule

// File: rtl/fifo_wr_packer.sv
// Packs RATIO narrow beats (LSB lane first) into one FIFO word and drives the
// FIFO write port from a 1-entry output register, with debug counters.
module fifo_wr_packer
  import fifo_pkg::*;
#(
  parameter int                  IN_WIDTH   = 4,
  parameter int                  DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int                  RATIO      = DATA_WIDTH / IN_WIDTH,
  parameter logic [IN_WIDTH-1:0] PAD_VALUE  = IN_WIDTH'(fifo_pkg::PAD_VALUE),
  parameter int                  CNT_WIDTH  = fifo_pkg::CNT_WIDTH
) (
  input  logic                  wr_clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_WIDTH-1:0]   in_data,
  input  logic                  in_last,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_wdata,
  input  logic                  fifo_full,
  input  logic                  fifo_overflow,
  output logic                  err_overflow,
  output logic [CNT_WIDTH-1:0]  words_written,
  output logic [CNT_WIDTH-1:0]  stall_cycles,
  output logic                  busy
);
  localparam int LW = (RATIO > 1) ? $clog2(RATIO) : 1;

  if (DATA_WIDTH % IN_WIDTH != 0 || RATIO < 2 || RATIO * IN_WIDTH != DATA_WIDTH) begin : g_chk
    $fatal(1, "fifo_wr_packer: DATA_WIDTH must be a multiple (>=2) of IN_WIDTH");
  end

  typedef logic [RATIO-1:0][IN_WIDTH-1:0] lanes_t;

  logic [LW-1:0]         lane_cnt;
  lanes_t                pack_reg, word;
  logic [DATA_WIDTH-1:0] out_reg;
  logic                  out_valid, accept, complete;
  pack_state_e           state;

  assign in_ready   = !rst && (!out_valid || !fifo_full);
  assign accept     = in_valid && in_ready;
  assign complete   = accept && (lane_cnt == LW'(RATIO - 1) || in_last);
  assign fifo_wr_en = !rst && out_valid && !fifo_full;
  assign fifo_wdata = out_reg;
  assign state      = (lane_cnt == '0) ? PK_EMPTY : PK_PARTIAL;
  assign busy       = out_valid || (state == PK_PARTIAL);

  // Current beat drops into its lane; lanes above it pad out an early in_last.
  always_comb begin
    word = pack_reg;
    for (int i = 0; i < RATIO; i++) begin
      if (i == int'(lane_cnt))     word[i] = in_data;
      else if (i > int'(lane_cnt)) word[i] = PAD_VALUE;
    end
  end

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      lane_cnt     <= '0;
      pack_reg     <= '0;
      out_reg      <= '0;
      out_valid    <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      if (fifo_wr_en) out_valid <= 1'b0;
      // A completing beat reloads the output register even on a write edge.
      if (complete) begin
        out_reg   <= word;
        out_valid <= 1'b1;
        lane_cnt  <= '0;
        pack_reg  <= '0;
      end else if (accept) begin
        pack_reg[lane_cnt] <= in_data;
        lane_cnt           <= lane_cnt + 1'b1;
      end
      if (fifo_overflow) err_overflow <= 1'b1;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_words_cnt (
    .wr_clk (wr_clk),
    .rst    (rst),
    .inc    (fifo_wr_en),
    .count  (words_written)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .wr_clk (wr_clk),
    .rst    (rst),
    .inc    (out_valid && fifo_full),
    .count  (stall_cycles)
  );
endmodule

// File: tb/tb_fifo_wr_packer.sv
// Directed bench for fifo_wr_packer: a queue-based packing model checked every
// cycle, plus literal expectations for each scenario.
module tb_fifo_wr_packer;
  localparam int IW = 4;
  localparam int DW = 8;
  localparam int R  = DW / IW;
  localparam int CW = 16;
  localparam logic [IW-1:0] PAD = 4'h0;

  logic          wr_clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0, in_last = 1'b0;
  logic [IW-1:0] in_data = '0;
  logic          fifo_full = 1'b0, fifo_overflow = 1'b0;
  logic          in_ready, fifo_wr_en, err_overflow, busy;
  logic [DW-1:0] fifo_wdata;
  logic [CW-1:0] words_written, stall_cycles;

  fifo_wr_packer #(.IN_WIDTH(IW), .DATA_WIDTH(DW), .PAD_VALUE(PAD), .CNT_WIDTH(CW)) dut (
    .wr_clk        (wr_clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_last       (in_last),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_wdata    (fifo_wdata),
    .fifo_full     (fifo_full),
    .fifo_overflow (fifo_overflow),
    .err_overflow  (err_overflow),
    .words_written (words_written),
    .stall_cycles  (stall_cycles),
    .busy          (busy)
  );

  always #5 wr_clk = ~wr_clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: beats of the word being built, one pending output word, counters.
  logic [IW-1:0] partial[$];
  logic          m_pend_v = 1'b0;
  logic [DW-1:0] m_pend_w = '0;
  logic [CW-1:0] m_words = '0, m_stalls = '0;
  logic          m_ovf = 1'b0;
  bit            armed = 1'b0;
  logic [DW-1:0] wr_log[$];

  // Inputs change just after posedge, so at negedge they are what the next edge samples.
  always @(negedge wr_clk) begin
    logic exp_ready, exp_wr, acc;
    logic [DW-1:0] w;
    exp_ready = !rst && (!m_pend_v || !fifo_full);
    exp_wr    = !rst && m_pend_v && !fifo_full;
    if (armed) begin
      chk("in_ready", in_ready, exp_ready);
      chk("fifo_wr_en", fifo_wr_en, exp_wr);
      chk("fifo_wdata", fifo_wdata, m_pend_w);
      chk("words_written", words_written, m_words);
      chk("stall_cycles", stall_cycles, m_stalls);
      chk("err_overflow", err_overflow, m_ovf);
      chk("busy", busy, m_pend_v || partial.size() != 0);
    end
    if (fifo_wr_en === 1'b1) wr_log.push_back(fifo_wdata);
    if (rst) begin
      partial.delete();
      m_pend_v = 1'b0; m_pend_w = '0;
      m_words = '0; m_stalls = '0; m_ovf = 1'b0;
      armed = 1'b1;
    end else begin
      acc = in_valid && exp_ready;
      if (exp_wr && m_words != '1) m_words++;
      if (m_pend_v && fifo_full && m_stalls != '1) m_stalls++;
      if (fifo_overflow) m_ovf = 1'b1;
      if (exp_wr) m_pend_v = 1'b0;
      if (acc) begin
        partial.push_back(in_data);
        if (partial.size() == R || in_last) begin
          w = '0;
          for (int i = 0; i < R; i++)
            w[i*IW +: IW] = (i < partial.size()) ? partial[i] : PAD;
          m_pend_w = w;
          m_pend_v = 1'b1;
          partial.delete();
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge wr_clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    wr_log.delete();
  endtask

  task automatic beat(input logic [IW-1:0] d, input logic last);
    bit acc = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge wr_clk);
      acc = in_ready;
      @(posedge wr_clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    if (!acc) chk("beat_accept_timeout", 0, 1);
  endtask

  initial begin
    tick(2);
    rst = 1'b0;
    chk("reset_wdata", fifo_wdata, 8'h00);
    chk("reset_words", words_written, 0);
    chk("reset_busy", busy, 0);
    chk("reset_wr_en", fifo_wr_en, 0);

    // Two-beat word, LSB lane first
    do_reset();
    beat(4'h3, 0);
    beat(4'hA, 0);
    @(negedge wr_clk);
    chk("t1_wr_en", fifo_wr_en, 1);
    chk("t1_busy_at_write", busy, 1);
    @(negedge wr_clk);
    chk("t1_busy_after", busy, 0);
    tick(2);
    chk("t1_nwrites", wr_log.size(), 1);
    if (wr_log.size() > 0) chk("t1_word", wr_log[0], 8'hA3);
    chk("t1_words", words_written, 1);

    // Early last pads the upper lane
    do_reset();
    beat(4'h5, 1);
    tick(3);
    chk("t2_nwrites", wr_log.size(), 1);
    if (wr_log.size() > 0) chk("t2_word", wr_log[0], 8'h05);
    chk("t2_busy", busy, 0);

    // Back-to-back stream
    do_reset();
    for (int i = 0; i < 32; i++) beat(IW'(i), 0);
    tick(3);
    chk("t3_nwrites", wr_log.size(), 16);
    if (wr_log.size() > 1) begin
      chk("t3_word0", wr_log[0], 8'h10);
      chk("t3_word1", wr_log[1], 8'h32);
      chk("t3_word15", wr_log[15], 8'hFE);
    end
    chk("t3_words", words_written, 16);

    // Stall against a full FIFO
    do_reset();
    fifo_full = 1'b1;
    beat(4'h1, 0);
    beat(4'h2, 0);
    tick(5);
    chk("t4_no_write", wr_log.size(), 0);
    chk("t4_stalls", stall_cycles, 5);
    chk("t4_wdata_held", fifo_wdata, 8'h21);
    chk("t4_ready_low", in_ready, 0);
    fifo_full = 1'b0;
    tick(3);
    chk("t4_nwrites", wr_log.size(), 1);
    if (wr_log.size() > 0) chk("t4_word", wr_log[0], 8'h21);
    chk("t4_words", words_written, 1);
    chk("t4_stalls_final", stall_cycles, 5);

    // Reset discards a partial word
    do_reset();
    beat(4'h7, 0);
    chk("t5_busy_partial", busy, 1);
    do_reset();
    chk("t5_words0", words_written, 0);
    chk("t5_stalls0", stall_cycles, 0);
    chk("t5_busy0", busy, 0);
    beat(4'h1, 0);
    beat(4'h2, 0);
    tick(3);
    chk("t5_nwrites", wr_log.size(), 1);
    if (wr_log.size() > 0) chk("t5_word", wr_log[0], 8'h21);

    // Sticky overflow flag
    do_reset();
    fifo_overflow = 1'b1;
    tick(1);
    fifo_overflow = 1'b0;
    tick(1);
    chk("t6_err_set", err_overflow, 1);
    beat(4'h5, 0);
    beat(4'h6, 0);
    tick(3);
    chk("t6_err_held", err_overflow, 1);
    if (wr_log.size() > 0) chk("t6_word", wr_log[0], 8'h65);
    do_reset();
    tick(1);
    chk("t6_err_clr", err_overflow, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fifo_wr_packer.md
Name:
fifo_wr_packer

Overview:
- Write-side front end for the async FIFO, running entirely in the wr_clk domain.
- Accepts a narrow valid/ready beat stream and packs RATIO beats into one DATA_WIDTH word. Packing is LSB lane first.
- Drives the FIFO write port through a 1-entry output register and never asserts a write while the FIFO reports full.
- Provides sticky overflow detection and saturating statistics for debug.

Parameters:
- IN_WIDTH, 4, input beat width in bits.
- DATA_WIDTH, 8, FIFO word width in bits. Must equal the FIFO's DATA_WIDTH.
- RATIO, DATA_WIDTH/IN_WIDTH, beats per word (derived, do not override).
- PAD_VALUE, 0, IN_WIDTH-bit value that fills unused lanes on an early in_last.
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- wr_clk  in  1  write-domain clock.
- rst  in  1  synchronous, active-high reset, sampled on wr_clk.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  upstream beat accept.
- in_data  in  IN_WIDTH  beat payload.
- in_last  in  1  final beat of a packet; qualified by in_valid&&in_ready.
- fifo_wr_en  out  1  FIFO write enable.
- fifo_wdata  out  DATA_WIDTH  FIFO write data.
- fifo_full  in  1  FIFO full flag, combinational in the wr_clk domain.
- fifo_overflow  in  1  FIFO overflow flag.
- err_overflow  out  1  sticky: an overflow was observed.
- words_written  out  CNT_WIDTH  saturating count of FIFO writes.
- stall_cycles  out  CNT_WIDTH  saturating count of cycles with out_valid && fifo_full.
- busy  out  1  high when a partial word is held or out_valid=1.

Behaviour:
- Reset values (rst=1 at a wr_clk edge):
  - in_ready=0 during reset.
  - fifo_wr_en=0, fifo_wdata=0, err_overflow=0, words_written=0, stall_cycles=0, busy=0.
  - Internal state: lane_cnt=0, pack_reg=0, out_valid=0.
- Reset mid-operation: the partial word and any pending out_reg word are discarded. No write is issued on the reset cycle. The FIFO shares the same rst.
- Beat acceptance: accept = in_valid && in_ready, with in_ready = !rst && (!out_valid || !fifo_full). This is combinational.
- Accepted beat handling:
  - The beat is written into pack_reg lane lane_cnt, at bits [lane_cnt*IN_WIDTH +: IN_WIDTH].
  - Word completes when lane_cnt==RATIO-1 or in_last=1.
  - On completion: out_reg <= assembled word, with every lane above the current lane set to PAD_VALUE. At the same edge out_valid<=1, lane_cnt<=0 and pack_reg<=0.
  - Otherwise lane_cnt increments.
- FIFO write:
  - fifo_wr_en = out_valid && !fifo_full (combinational); fifo_wdata = out_reg.
  - On a write edge out_valid clears, unless a new word completes at the same edge. In that case out_reg reloads and out_valid stays 1.
  - Sustained throughput is one beat per cycle.
- Latency: the word-completing beat accepted at edge N gives fifo_wr_en=1 during cycle N→N+1 (if not full). The word enters the FIFO at edge N+1.
- Full boundary:
  - While out_valid && fifo_full: fifo_wr_en=0, in_ready=0, out_reg held stable, stall_cycles increments.
  - A write is never issued while fifo_full=1, so the FIFO's overflow never sets through this block.
- Lane counter acts as the state machine:
  - EMPTY: lane_cnt=0, no partial word.
  - PARTIAL: 0<lane_cnt<RATIO.
  - EMPTY→PARTIAL on an accepted beat without completion.
  - PARTIAL→EMPTY on a completing beat.
  - An in_last beat in EMPTY completes immediately: a single-lane word plus padding.
- Counters saturate at all-ones; there is no wrap.
  - words_written increments on each fifo_wr_en cycle.
  - err_overflow sets on any cycle with fifo_overflow=1 and clears only on rst.
- busy = out_valid || (lane_cnt!=0).
- Elaboration check: DATA_WIDTH % IN_WIDTH == 0 and RATIO >= 2, otherwise a fatal error.

Decomposition:
- Shared package fifo_pkg holds:
  - DATA_WIDTH default 8 and FIFO_SIZE default 16.
  - CNT_WIDTH 16.
  - PAD_VALUE default.
  - An enum for the EMPTY/PARTIAL state used by checkers.
- One sub-module, sat_counter (parameter WIDTH; inputs inc and rst; output count, saturating). It is instantiated twice, for words_written and stall_cycles.

Test Plan:
- All cases use IN_WIDTH=4 and DATA_WIDTH=8.
- rst, then beats 0x3,0xA with fifo_full=0 → single fifo_wr_en pulse with fifo_wdata=0xA3; words_written=1; busy falls one cycle after the write.
- Single beat 0x5 with in_last=1 → fifo_wdata=0x05 (upper lane PAD_VALUE=0); lane_cnt returns to 0.
- 32 back-to-back beats 0x0..0xF repeated, fifo_full=0 → 16 writes, in_ready held 1, first word 0x10, then 0x32 and so on; words_written=16.
- Hold fifo_full=1 while out_valid=1 for 5 cycles → fifo_wr_en=0, in_ready=0, fifo_wdata stable, stall_cycles=5. Release full → exactly one write of the held word.
- Accept beat 0x7, then assert rst for one cycle, then beats 0x1,0x2 → only write is 0x21 and 0x7 never appears; counters are 0 before the write.
- Pulse fifo_overflow for one cycle → err_overflow=1 and held through later traffic until rst clears it.
